// File: rtl/pool_writeback.sv
// Pooling-stage writeback: captures col-wide pooled vectors into a 2-entry FIFO and
// serializes them to SRAM as lanes-word beats. Optional macro POOL_WB_RELU_EN clamps negatives to 0.
module pool_writeback #(
  parameter int data_width = 16,
  parameter int col        = 32,
  parameter int lanes      = 4,
  parameter int addr_width = 10,
  parameter int cnt_width  = 12
) (
  input  logic                                clk,
  input  logic                                nrst,
  input  logic                                start,
  input  logic [addr_width-1:0]               base_addr,
  input  logic [cnt_width-1:0]                num_vectors,
  input  logic [col-1:0][data_width-1:0]      pooling_out,
  input  logic [col-1:0]                      pooling_done,
  output logic                                pool_ready,
  output logic                                mem_wr_en,
  input  logic                                mem_ready,
  output logic [addr_width-1:0]               mem_addr,
  output logic [lanes*data_width-1:0]         mem_wdata,
  output logic                                busy,
  output logic                                done,
  output logic                                skew_err,
  output logic                                ovf_err
);
  localparam int BEATS = col / lanes;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [1:0][col-1:0][data_width-1:0] fifo;
  logic [col-1:0][data_width-1:0]      vec_in;
  logic                                wr_ptr, rd_ptr;
  logic [1:0]                          count, count_nxt;
  logic [BW-1:0]                       beat;
  logic [cnt_width-1:0]                cap_cnt, cap_cnt_nxt, num_q;
  logic                                all_done, any_done, full, capture, beat_acc, pop;

  for (genvar i = 0; i < col; i++) begin : g_lane
`ifdef POOL_WB_RELU_EN
    assign vec_in[i] = pooling_out[i][data_width-1] ? '0 : pooling_out[i];
`else
    assign vec_in[i] = pooling_out[i];
`endif
  end

  assign all_done    = &pooling_done;
  assign any_done    = |pooling_done;
  assign full        = (count == 2'd2);
  assign capture     = (state == S_RUN) && all_done && !full;
  assign beat_acc    = mem_wr_en && mem_ready;
  assign pop         = beat_acc && (beat == BW'(BEATS - 1));
  assign count_nxt   = 2'(count + 2'(capture) - 2'(pop));
  assign cap_cnt_nxt = cap_cnt + cnt_width'(capture);

  assign pool_ready = !full;
  assign mem_wr_en  = (count != 2'd0);
  assign mem_wdata  = fifo[rd_ptr][int'(beat)*lanes +: lanes];
  assign busy       = (state == S_RUN) || (state == S_DRAIN);
  assign done       = (state == S_DONE);

  // Leave RUN on the same edge as the final capture so no stray capture can slip in.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (cap_cnt_nxt == num_q) state_nxt = S_DRAIN;
      S_DRAIN: if (count_nxt == 2'd0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count    <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      beat     <= '0;
      cap_cnt  <= '0;
      num_q    <= '0;
      mem_addr <= '0;
      skew_err <= 1'b0;
      ovf_err  <= 1'b0;
    end else begin
      if ((state == S_IDLE) && start) begin
        num_q    <= num_vectors;
        mem_addr <= base_addr;
        cap_cnt  <= '0;
        skew_err <= 1'b0;
        ovf_err  <= 1'b0;
      end else begin
        if (capture)  cap_cnt  <= cap_cnt_nxt;
        if (beat_acc) mem_addr <= mem_addr + addr_width'(1);
      end
      if ((state == S_RUN) && any_done && !all_done) skew_err <= 1'b1;
      if ((state == S_RUN) && all_done && full)      ovf_err  <= 1'b1;
      count <= count_nxt;
      if (capture)  wr_ptr <= ~wr_ptr;
      if (pop)      rd_ptr <= ~rd_ptr;
      if (beat_acc) beat   <= pop ? '0 : beat + BW'(1);
    end
  end

  // Payload storage needs no reset; the count alone says what is valid.
  always_ff @(posedge clk) begin
    if (capture) fifo[wr_ptr] <= vec_in;
  end
endmodule

// File: tb/tb_pool_writeback.sv
// Randomized and directed bench for pool_writeback against a queue-of-vectors reference model.
module tb_pool_writeback;
  localparam int DW = 16, COL = 32, LN = 4, AW = 10, CW = 12, BEATS = COL / LN;
  typedef logic [COL-1:0][DW-1:0] vec_t;

  logic clk, nrst, start, pool_ready, mem_wr_en, mem_ready, busy, done, skew_err, ovf_err;
  logic [AW-1:0] base_addr, mem_addr;
  logic [CW-1:0] num_vectors;
  vec_t pooling_out;
  logic [COL-1:0] pooling_done;
  logic [LN*DW-1:0] mem_wdata;

  pool_writeback #(.data_width(DW), .col(COL), .lanes(LN), .addr_width(AW), .cnt_width(CW)) dut (
    .clk(clk), .nrst(nrst), .start(start), .base_addr(base_addr), .num_vectors(num_vectors),
    .pooling_out(pooling_out), .pooling_done(pooling_done), .pool_ready(pool_ready),
    .mem_wr_en(mem_wr_en), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .skew_err(skew_err), .ovf_err(ovf_err));

  initial clk = 0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0, n_acc = 0, done_cnt = 0;
  int start_cyc = 0, done_cyc = 0, last_acc_cyc = 0, rdy_mode = 0;
  logic [AW-1:0] acc_addr[$];
  logic [LN*DW-1:0] acc_data[$];

  // Reference model: spec-level phase, queue of whole buffered vectors, beat index within head.
  vec_t mq[$];
  int m_mode = 0, m_beat = 0, m_cap = 0, m_num = 0, osz, pmode;
  logic [AW-1:0] m_addr;
  bit m_skew = 0, m_ovf = 0, popv;
  logic [LN*DW-1:0] ed;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t relu(vec_t v);
    vec_t r = v;
`ifdef POOL_WB_RELU_EN
    for (int i = 0; i < COL; i++) if (r[i][DW-1]) r[i] = '0;
`endif
    return r;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!nrst) begin
      mq.delete(); m_mode = 0; m_beat = 0; m_cap = 0; m_num = 0; m_skew = 0; m_ovf = 0;
    end else begin
      chk("busy", busy, (m_mode == 1 || m_mode == 2));
      chk("done", done, (m_mode == 3));
      chk("pool_ready", pool_ready, (mq.size() < 2));
      chk("mem_wr_en", mem_wr_en, (mq.size() > 0));
      chk("skew_err", skew_err, m_skew);
      chk("ovf_err", ovf_err, m_ovf);
      if (mq.size() > 0) begin
        for (int k = 0; k < LN; k++) ed[k*DW +: DW] = mq[0][m_beat*LN + k];
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, ed);
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (start && m_mode == 0) start_cyc = cyc;
      if (mem_wr_en && mem_ready) begin
        n_acc++; last_acc_cyc = cyc;
        acc_addr.push_back(mem_addr); acc_data.push_back(mem_wdata);
      end
      // advance model across the coming edge
      osz = mq.size(); pmode = m_mode; popv = 0;
      if (osz > 0 && mem_ready) begin
        m_addr = m_addr + 1'b1; m_beat++;
        if (m_beat == BEATS) begin m_beat = 0; popv = 1; end
      end
      if (pmode == 1) begin
        if (&pooling_done) begin
          if (osz < 2) begin mq.push_back(relu(pooling_out)); m_cap++; end
          else m_ovf = 1;
        end else if (|pooling_done) m_skew = 1;
      end
      if (popv) void'(mq.pop_front());
      case (pmode)
        0: if (start) begin
             m_mode = 1; m_addr = base_addr; m_num = int'(num_vectors); m_cap = 0; m_skew = 0; m_ovf = 0;
           end
        1: if (m_cap == m_num) m_mode = 2;
        2: if (mq.size() == 0) m_mode = 3;
        default: m_mode = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    case (rdy_mode)
      0: mem_ready = 1'b1;
      1: mem_ready = ~mem_ready;
      2: mem_ready = 1'($urandom_range(0, 1));
      default: mem_ready = 1'b0;
    endcase
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [CW-1:0] n);
    start = 1; base_addr = b; num_vectors = n;
    tick();
    start = 0;
  endtask

  task automatic offer(input vec_t v);
    pooling_out = v; pooling_done = '1;
    tick();
    pooling_done = '0;
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < COL; i++) v[i] = DW'($urandom);
    return v;
  endfunction

  task automatic wait_done(input int bound, input string nm);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < bound) begin tick(); n++; end
    checks++;
    if (done_cnt == d0) begin errors++; $display("FAIL %s: done not seen within %0d cycles", nm, bound); end
  endtask

  task automatic wait_ready(input int bound);
    int n = 0;
    while (!pool_ready && n < bound) begin tick(); n++; end
    chk("wait_pool_ready", pool_ready, 1);
  endtask

  vec_t v;
  int n0;
  logic [LN*DW-1:0] d;
  logic [COL-1:0] pd;

  initial begin
    nrst = 0; start = 0; base_addr = '0; num_vectors = '0; pooling_out = '0;
    pooling_done = '0; mem_ready = 1;
    repeat (3) tick();
    chk("rst_pool_ready", pool_ready, 1);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    nrst = 1;
    tick();

    // single vector, word i = i
    rdy_mode = 0; n0 = acc_addr.size();
    do_start(10'h010, 1);
    for (int i = 0; i < COL; i++) v[i] = DW'(i);
    offer(v);
    wait_done(100, "t1_done");
    chk("t1_beats", acc_addr.size() - n0, 8);
    chk("t1_addr0", acc_addr[n0], 10'h010);
    chk("t1_addr7", acc_addr[n0+7], 10'h017);
    chk("t1_data0", acc_data[n0], 64'h0003_0002_0001_0000);
    chk("t1_done_lat", done_cyc - last_acc_cyc, 1);

    // backpressure with mem_ready toggling
    rdy_mode = 1; n0 = n_acc;
    do_start(10'h100, 3);
    offer(rand_vec());
    offer(rand_vec());
    chk("t2_pool_ready_low", pool_ready, 0);
    wait_ready(100);
    offer(rand_vec());
    wait_done(200, "t2_done");
    chk("t2_beats", n_acc - n0, 24);

    // overflow with SRAM stalled
    rdy_mode = 3; tick(); n0 = n_acc;
    do_start(10'h000, 3);
    offer(rand_vec()); offer(rand_vec()); offer(rand_vec());
    chk("t3_ovf", ovf_err, 1);
    rdy_mode = 0;
    repeat (20) tick();
    chk("t3_beats", n_acc - n0, 16);
    offer(rand_vec());
    wait_done(100, "t3_done");

    // skew: partial pattern, no capture; flags cleared by start
    do_start(10'h200, 1);
    chk("t4_ovf_clr", ovf_err, 0);
    pooling_done = 32'h0000_FFFF;
    tick();
    pooling_done = '0;
    chk("t4_skew", skew_err, 1);
    chk("t4_no_capture", mem_wr_en, 0);
    offer(rand_vec());
    wait_done(100, "t4_done");

    // address wrap
    n0 = acc_addr.size();
    do_start(10'h3FC, 1);
    offer(rand_vec());
    wait_done(100, "t5_done");
    chk("t5_addr0", acc_addr[n0], 10'h3FC);
    chk("t5_addr4", acc_addr[n0+4], 10'h000);
    chk("t5_addr7", acc_addr[n0+7], 10'h003);

    // zero vectors
    n0 = n_acc;
    do_start(10'h055, 0);
    wait_done(10, "t6_done");
    chk("t6_done_lat", done_cyc - start_cyc, 3);
    chk("t6_no_writes", n_acc - n0, 0);

    // negative word
    n0 = acc_data.size();
    do_start(10'h000, 1);
    v = rand_vec(); v[0] = 16'h8001;
    offer(v);
    wait_done(100, "t7_done");
    d = acc_data[n0];
`ifdef POOL_WB_RELU_EN
    chk("t7_relu", d[15:0], 16'h0000);
`else
    chk("t7_relu", d[15:0], 16'h8001);
`endif

    // reset mid-beat
    rdy_mode = 1;
    do_start(10'h000, 2);
    offer(rand_vec());
    repeat (3) tick();
    #2 nrst = 0;
    #1;
    chk("t8_wr_en", mem_wr_en, 0);
    chk("t8_busy", busy, 0);
    chk("t8_pool_ready", pool_ready, 1);
    tick();
    nrst = 1;
    tick();

    // randomized layers
    rdy_mode = 2;
    for (int l = 0; l < 8; l++) begin
      int d0, n, r;
      do_start(AW'($urandom), CW'($urandom_range(0, 4)));
      d0 = done_cnt; n = 0;
      while (done_cnt == d0 && n < 3000) begin
        r = $urandom_range(0, 7);
        pooling_out = rand_vec();
        pd = '0;
        if (r < 4) pd = '1;
        else if (r == 4) begin
          pd = COL'($urandom);
          if (pd == '0 || pd == '1) pd = 32'h1;
        end
        pooling_done = pd;
        start = (r == 7);
        base_addr = AW'($urandom);
        tick(); n++;
      end
      start = 0; pooling_done = '0;
      checks++;
      if (done_cnt == d0) begin errors++; $display("FAIL rand_layer_%0d: done not seen", l); end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
